// File: rtl/ft64_irq_agent.sv
// Per-core interrupt target agent: level request to the core plus enable/disable/EOI bus writes.
// Optional bus timeout is enabled by defining FT64_IRQ_AGENT_TIMEOUT_EN.
module ft64_irq_agent #(
    parameter int unsigned        AW        = 32,
    parameter logic [AW-1:0]      PLIC_BASE = 32'hFFDC_0000,
    parameter int unsigned        TO_CYC    = 255
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [3:0]    irq_i,
    input  logic [3:0]    im_i,
    output logic          int_o,
    output logic [3:0]    int_lvl_o,
    input  logic          int_ack_i,
    output logic [3:0]    cur_lvl_o,
    input  logic          cmd_valid_i,
    output logic          cmd_ready_o,
    input  logic [1:0]    cmd_op_i,
    input  logic [63:0]   cmd_dat_i,
    output logic          done_o,
    output logic          err_o,
    output logic          cyc_o,
    output logic          stb_o,
    output logic          we_o,
    output logic [AW-1:0] adr_o,
    output logic [63:0]   dat_o,
    input  logic          ack_i
);

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_BUS  = 1'b1;

    logic          state_q, state_d;
    logic [3:0]    irq_q;
    logic          held_q, held_d;
    logic [3:0]    cur_lvl_q, cur_lvl_d;
    logic [1:0]    op_q, op_d;
    logic [AW-1:0] adr_q, adr_d;
    logic [63:0]   dat_q, dat_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
`ifdef FT64_IRQ_AGENT_TIMEOUT_EN
    logic [15:0]   to_cnt_q, to_cnt_d;
`endif

    assign int_o       = (irq_q > im_i) && (!held_q || (irq_q > cur_lvl_q));
    assign int_lvl_o   = int_o ? irq_q : 4'd0;
    assign cur_lvl_o   = cur_lvl_q;
    // Gated by reset so every output reads 0 while reset is held.
    assign cmd_ready_o = rst_i && (state_q == ST_IDLE);
    assign cyc_o       = (state_q == ST_BUS);
    assign stb_o       = (state_q == ST_BUS);
    assign we_o        = (state_q == ST_BUS);
    assign adr_o       = adr_q;
    assign dat_o       = dat_q;
    assign done_o      = done_q;
    assign err_o       = err_q;

    always_comb begin
        state_d   = state_q;
        held_d    = held_q;
        cur_lvl_d = cur_lvl_q;
        op_d      = op_q;
        adr_d     = adr_q;
        dat_d     = dat_q;
        done_d    = 1'b0;
        err_d     = err_q;
`ifdef FT64_IRQ_AGENT_TIMEOUT_EN
        to_cnt_d  = '0;
`endif
        if (state_q == ST_IDLE) begin
            if (cmd_valid_i) begin
                op_d  = cmd_op_i;
                err_d = 1'b0;
                case (cmd_op_i)
                    2'b00: begin
                        adr_d   = PLIC_BASE + AW'(12'h018);
                        dat_d   = {58'b0, cmd_dat_i[5:0]};
                        state_d = ST_BUS;
                    end
                    2'b01: begin
                        adr_d   = PLIC_BASE + AW'(12'h008);
                        dat_d   = cmd_dat_i;
                        state_d = ST_BUS;
                    end
                    2'b10: begin
                        adr_d   = PLIC_BASE + AW'(12'h010);
                        dat_d   = cmd_dat_i;
                        state_d = ST_BUS;
                    end
                    default: begin
                        done_d = 1'b1;
                        err_d  = 1'b1;
                    end
                endcase
            end
        end else begin
            if (ack_i) begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
                if (op_q == 2'b00) begin
                    held_d    = 1'b0;
                    cur_lvl_d = 4'd0;
                end
`ifdef FT64_IRQ_AGENT_TIMEOUT_EN
            end else if (to_cnt_q == 16'(TO_CYC - 1)) begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
                err_d   = 1'b1;
            end else begin
                to_cnt_d = to_cnt_q + 16'd1;
`endif
            end
        end
        // A core acknowledge overrides a same-cycle EOI clear.
        if (int_o && int_ack_i) begin
            held_d    = 1'b1;
            cur_lvl_d = irq_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= ST_IDLE;
            irq_q     <= '0;
            held_q    <= 1'b0;
            cur_lvl_q <= '0;
            op_q      <= '0;
            adr_q     <= '0;
            dat_q     <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
`ifdef FT64_IRQ_AGENT_TIMEOUT_EN
            to_cnt_q  <= '0;
`endif
        end else begin
            state_q   <= state_d;
            irq_q     <= irq_i;
            held_q    <= held_d;
            cur_lvl_q <= cur_lvl_d;
            op_q      <= op_d;
            adr_q     <= adr_d;
            dat_q     <= dat_d;
            done_q    <= done_d;
            err_q     <= err_d;
`ifdef FT64_IRQ_AGENT_TIMEOUT_EN
            to_cnt_q  <= to_cnt_d;
`endif
        end
    end

endmodule
